// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: hunts for SYNC_BYTE, collects LEN/payload/XOR checksum,
// and releases only checksum-verified payloads through a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] out_len,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       rx_drop
);
    localparam int PW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [7:0]    len, len_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] idle, idle_nxt;
    logic [7:0]    data_nxt, olen_nxt;
    logic          valid_nxt, last_nxt, busy_nxt;
    logic          e_chk_nxt, e_len_nxt, e_to_nxt, drop_nxt;
    logic          mem_we;
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    len_m1;
    logic [PW-1:0] rd_inc;

    assign len_m1 = len - 8'd1;
    assign rd_inc = rd_ptr + PW'(1);

    always_comb begin
        state_nxt  = state;
        len_nxt    = len;
        chk_nxt    = chk;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        idle_nxt   = idle;
        data_nxt   = out_data;
        olen_nxt   = out_len;
        valid_nxt  = out_valid;
        last_nxt   = out_last;
        e_chk_nxt  = 1'b0;
        e_len_nxt  = 1'b0;
        e_to_nxt   = 1'b0;
        drop_nxt   = 1'b0;
        mem_we     = 1'b0;

        case (state)
            HUNT: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_nxt = LEN;
                    chk_nxt   = 8'd0;
                    idle_nxt  = '0;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (rx_byte != 8'd0 && rx_byte <= MAX_LEN_B) begin
                        len_nxt    = rx_byte;
                        chk_nxt    = rx_byte;
                        wr_ptr_nxt = '0;
                        state_nxt  = PAYLOAD;
                    end else begin
                        e_len_nxt = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    mem_we     = 1'b1;
                    chk_nxt    = chk ^ rx_byte;
                    wr_ptr_nxt = wr_ptr + PW'(1);
                    if (8'(wr_ptr) == len_m1) state_nxt = CHK;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_byte == chk) begin
                        state_nxt  = DRAIN;
                        rd_ptr_nxt = '0;
                        valid_nxt  = 1'b1;
                        data_nxt   = mem[{AW{1'b0}}];
                        olen_nxt   = len;
                        last_nxt   = (len == 8'd1);
                    end else begin
                        e_chk_nxt = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            DRAIN: begin
                drop_nxt = rx_valid;
                if (out_valid && out_ready) begin
                    if (8'(rd_ptr) == len_m1) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                        state_nxt = HUNT;
                    end else begin
                        rd_ptr_nxt = rd_inc;
                        data_nxt   = mem[rd_inc[AW-1:0]];
                        last_nxt   = (8'(rd_inc) == len_m1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase

        // A byte arriving on the terminal cycle takes priority over the timeout.
        if (state inside {LEN, PAYLOAD, CHK}) begin
            if (rx_valid) begin
                idle_nxt = '0;
            end else if (idle == IDLE_LAST) begin
                idle_nxt  = '0;
                e_to_nxt  = 1'b1;
                state_nxt = HUNT;
            end else begin
                idle_nxt = idle + CW'(1);
            end
        end

        busy_nxt = (state_nxt != HUNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            len         <= 8'd0;
            chk         <= 8'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            idle        <= '0;
            out_data    <= 8'd0;
            out_len     <= 8'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            rx_drop     <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            chk         <= chk_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            idle        <= idle_nxt;
            out_data    <= data_nxt;
            out_len     <= olen_nxt;
            out_valid   <= valid_nxt;
            out_last    <= last_nxt;
            busy        <= busy_nxt;
            err_chk     <= e_chk_nxt;
            err_len     <= e_len_nxt;
            err_timeout <= e_to_nxt;
            rx_drop     <= drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= rx_byte;
    end

endmodule
